// File: rtl/video_timing_pkg.sv
// Shared types and timing constants for the DMG PPU line/dot timing.
// Mode encoding matches STAT[1:0].
package video_timing_pkg;

    typedef enum logic [1:0] {
        MODE_HBLANK = 2'd0,
        MODE_VBLANK = 2'd1,
        MODE_OAM    = 2'd2,
        MODE_XFER   = 2'd3
    } ppu_mode_t;

    localparam logic [8:0] DOTS_PER_LINE   = 9'd456;
    localparam logic [7:0] LINES_PER_FRAME = 8'd154;
    localparam logic [7:0] VBLANK_LINE     = 8'd144;
    localparam logic [8:0] OAM_DOTS        = 9'd80;
    localparam logic [8:0] MODE3_MAX       = 9'd289;
    localparam logic [8:0] LY153_ZERO_DOT  = 9'd4;

    localparam int STAT_IE_HBLANK = 0;
    localparam int STAT_IE_VBLANK = 1;
    localparam int STAT_IE_OAM    = 2;
    localparam int STAT_IE_LYC    = 3;

endpackage

// File: rtl/lcd_line_timing_stat_irq_gen.sv
// STAT interrupt combiner with rising-edge-only pulse generation.
// Overlapping sources keep the line high, so no second pulse is raised.
import video_timing_pkg::*;

module stat_irq_gen (
    input  logic       clk,
    input  logic       nreset,
    input  logic       en,
    input  logic       active,
    input  ppu_mode_t  mode,
    input  logic       lyc_match,
    input  logic [3:0] stat_ie,
    output logic       int_stat
);

    logic stat_line;
    logic stat_line_q;

    // OR of all enabled STAT sources; quiet until the timing is running
    always_comb begin
        stat_line = active & (
            (stat_ie[STAT_IE_HBLANK] & (mode == MODE_HBLANK)) |
            (stat_ie[STAT_IE_VBLANK] & (mode == MODE_VBLANK)) |
            (stat_ie[STAT_IE_OAM]    & (mode == MODE_OAM))    |
            (stat_ie[STAT_IE_LYC]    & lyc_match));
    end

    // Edge detect the combined line into a one-cycle request
    always_ff @(posedge clk) begin
        if (!nreset || !en) begin
            stat_line_q <= 1'b0;
            int_stat    <= 1'b0;
        end else begin
            stat_line_q <= stat_line;
            int_stat    <= stat_line & ~stat_line_q;
        end
    end

endmodule

// File: rtl/lcd_line_timing.sv
// Scanline/dot timing generator: LY, dot index, PPU mode and IRQs.
// Optional macro LY153_QUIRK_EN: LY reads 0 from dot 4 of line 153.
import video_timing_pkg::*;

module lcd_line_timing (
    input  logic       clk,
    input  logic       nreset,
    input  logic       lcd_en,
    input  logic [7:0] lyc,
    input  logic [3:0] stat_ie,
    input  logic       rend_done,
    output logic [7:0] v,
    output logic [8:0] lx,
    output ppu_mode_t  mode,
    output logic       lyc_match,
    output logic       int_vblank,
    output logic       int_stat
);

    logic       en_q;
    logic [7:0] ln_q;
    logic [8:0] cnt_q;
    logic [8:0] lx_n;
    logic [7:0] ln_n;
    logic [7:0] v_n;
    logic [8:0] cnt_n;
    ppu_mode_t  mode_n;

    // Next dot position, visible LY and mode for the coming dot
    always_comb begin
        lx_n = lx + 9'd1;
        ln_n = ln_q;
        if (!en_q) begin
            lx_n = '0;
            ln_n = '0;
        end else if (lx == DOTS_PER_LINE - 9'd1) begin
            lx_n = '0;
            ln_n = (ln_q == LINES_PER_FRAME - 8'd1) ? 8'd0 : ln_q + 8'd1;
        end
        v_n = ln_n;
`ifdef LY153_QUIRK_EN
        if (ln_n == LINES_PER_FRAME - 8'd1 && lx_n >= LY153_ZERO_DOT) begin
            v_n = '0;
        end
`endif
        if (ln_n >= VBLANK_LINE) begin
            mode_n = MODE_VBLANK;
        end else if (lx_n < OAM_DOTS) begin
            mode_n = MODE_OAM;
        end else if (lx_n == OAM_DOTS) begin
            mode_n = MODE_XFER;
        end else if (mode == MODE_XFER && !rend_done && cnt_q < MODE3_MAX) begin
            mode_n = MODE_XFER;
        end else begin
            mode_n = MODE_HBLANK;
        end
        cnt_n = (mode_n == MODE_XFER) ? cnt_q + 9'd1 : 9'd0;
    end

    // Timing state; LCD off holds everything at reset values
    always_ff @(posedge clk) begin
        if (!nreset || !lcd_en) begin
            en_q       <= 1'b0;
            ln_q       <= '0;
            cnt_q      <= '0;
            v          <= '0;
            lx         <= '0;
            mode       <= MODE_HBLANK;
            lyc_match  <= 1'b0;
            int_vblank <= 1'b0;
        end else begin
            en_q       <= 1'b1;
            ln_q       <= ln_n;
            cnt_q      <= cnt_n;
            v          <= v_n;
            lx         <= lx_n;
            mode       <= mode_n;
            lyc_match  <= (v_n == lyc);
            int_vblank <= (ln_n == VBLANK_LINE) && (lx_n == 9'd0);
        end
    end

    stat_irq_gen u_stat (
        .clk       (clk),
        .nreset    (nreset),
        .en        (lcd_en),
        .active    (en_q),
        .mode      (mode),
        .lyc_match (lyc_match),
        .stat_ie   (stat_ie),
        .int_stat  (int_stat)
    );

endmodule

// File: tb/tb_lcd_line_timing.sv
// Directed testbench for lcd_line_timing.
// Inputs driven and outputs sampled on the falling clock edge.
import video_timing_pkg::*;

module tb_lcd_line_timing;

    logic       clk = 1'b0;
    logic       nreset;
    logic       lcd_en;
    logic [7:0] lyc;
    logic [3:0] stat_ie;
    logic       rend_done;
    logic [7:0] v;
    logic [8:0] lx;
    ppu_mode_t  mode;
    logic       lyc_match;
    logic       int_vblank;
    logic       int_stat;

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int nvb = 0;
    int nst = 0;
    int c0, nvb0, nst0;

`ifdef LY153_QUIRK_EN
    localparam int V153_LATE = 0;
    localparam int M153_LATE = 1;
`else
    localparam int V153_LATE = 153;
    localparam int M153_LATE = 0;
`endif

    lcd_line_timing dut (
        .clk        (clk),
        .nreset     (nreset),
        .lcd_en     (lcd_en),
        .lyc        (lyc),
        .stat_ie    (stat_ie),
        .rend_done  (rend_done),
        .v          (v),
        .lx         (lx),
        .mode       (mode),
        .lyc_match  (lyc_match),
        .int_vblank (int_vblank),
        .int_stat   (int_stat)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (int_vblank) nvb <= nvb + 1;
        if (int_stat)   nst <= nst + 1;
    end

    task automatic chk(input string tag, input int obs, input int exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic step(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic goto(input int tv, input int tx);
        int n = 0;
        while (!(int'(v) == tv && int'(lx) == tx) && n < 80000) begin
            @(negedge clk);
            n++;
        end
        chk($sformatf("reach_%0d_%0d", tv, tx), int'(n < 80000), 1);
    endtask

    initial begin
        nreset    = 1'b0;
        lcd_en    = 1'b0;
        lyc       = 8'd200;
        stat_ie   = 4'b0000;
        rend_done = 1'b0;
        step(3);
        chk("rst_v", int'(v), 0);
        chk("rst_lx", int'(lx), 0);
        chk("rst_mode", int'(mode), 0);
        chk("rst_lyc_match", int'(lyc_match), 0);
        chk("rst_irqs", int'({int_vblank, int_stat}), 0);

        nreset = 1'b1;
        lcd_en = 1'b1;
        step(1);
        chk("en_v", int'(v), 0);
        chk("en_lx", int'(lx), 0);
        chk("en_mode", int'(mode), 2);
        step(79);
        chk("lx79_mode", int'(mode), 2);
        step(1);
        chk("lx80", int'(lx), 80);
        chk("lx80_mode", int'(mode), 3);

        goto(5, 252);
        chk("l5_252_mode", int'(mode), 3);
        rend_done = 1'b1;
        step(1);
        rend_done = 1'b0;
        chk("l5_253_mode", int'(mode), 0);
        goto(5, 455);
        chk("l5_455_mode", int'(mode), 0);
        step(1);
        chk("l6_v", int'(v), 6);
        chk("l6_mode", int'(mode), 2);
        goto(6, 368);
        chk("l6_368_mode", int'(mode), 3);
        step(1);
        chk("l6_369_mode", int'(mode), 0);

        goto(9, 400);
        lyc     = 8'd10;
        stat_ie = 4'b1000;
        nst0    = nst;
        goto(10, 0);
        chk("l10_match", int'(lyc_match), 1);
        chk("l10_stat_lag", int'(int_stat), 0);
        step(1);
        chk("l10_stat", int'(int_stat), 1);
        goto(10, 455);
        chk("l10_end_match", int'(lyc_match), 1);
        step(1);
        chk("l11_match", int'(lyc_match), 0);
        chk("lyc_stat_count", nst - nst0, 1);
        stat_ie = 4'b0000;
        lyc     = 8'd200;

        goto(50, 200);
        lcd_en = 1'b0;
        step(1);
        chk("off_v", int'(v), 0);
        chk("off_lx", int'(lx), 0);
        chk("off_mode", int'(mode), 0);
        nvb0    = nvb;
        nst0    = nst;
        stat_ie = 4'b1111;
        step(3);
        chk("off_irqs", (nvb - nvb0) + (nst - nst0), 0);
        stat_ie = 4'b0000;
        lcd_en  = 1'b1;
        step(1);
        c0 = cyc;
        chk("reen_v", int'(v), 0);
        chk("reen_lx", int'(lx), 0);
        chk("reen_mode", int'(mode), 2);

        goto(11, 0);
        stat_ie = 4'b0011;
        goto(143, 368);
        chk("l143_368_mode", int'(mode), 3);
        step(1);
        chk("l143_369_mode", int'(mode), 0);
        nst0 = nst;
        step(1);
        chk("l143_hbl_stat", int'(int_stat), 1);
        goto(143, 455);
        nvb0 = nvb;
        step(1);
        chk("vbl_v", int'(v), 144);
        chk("vbl_lx", int'(lx), 0);
        chk("vbl_mode", int'(mode), 1);
        chk("vbl_irq", int'(int_vblank), 1);
        step(1);
        chk("vbl_irq_drop", int'(int_vblank), 0);
        goto(145, 0);
        chk("vbl_stat_count", nst - nst0, 1);
        chk("vbl_irq_count", nvb - nvb0, 1);

        goto(152, 0);
        lyc = 8'd0;
        goto(153, 3);
        chk("l153_3_v", int'(v), 153);
        chk("l153_3_match", int'(lyc_match), 0);
        step(1);
        chk("l153_4_v", int'(v), V153_LATE);
        chk("l153_4_match", int'(lyc_match), M153_LATE);
        goto(V153_LATE, 455);
        chk("l153_end_lx", int'(lx), 455);
        step(1);
        chk("wrap_v", int'(v), 0);
        chk("wrap_lx", int'(lx), 0);
        chk("wrap_mode", int'(mode), 2);
        chk("wrap_match", int'(lyc_match), 1);
        chk("frame_dots", cyc - c0, 70224);
        chk("wrap_no_vbl", nvb - nvb0, 1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
